a2d_scan_sched: RTL and testbench
=================================

# a2d_scan_sched

Conversion scheduler that sits directly upstream of the A2D SPI interface. On a programmable period tick it scans channels 0..NUM_CH-1 in order. For each channel it pulses the A2D start, waits for the conversion-complete flag and accumulates the 12-bit result. It averages 2^AVG_LOG2 scans per channel and exposes the averaged result of every channel through a combinational read port.

## Interface
- NUM_CH, 8: channels scanned per pass, legal 1..8
- PERIOD, 50000: clk cycles between scan ticks, legal 2..65535
- AVG_LOG2, 2: log2 of scans averaged per published result, legal 0..4
- clk  in  1  clock; everything is on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  scan enable
- strt_cnv  out  1  one-cycle start pulse to the A2D interface
- chnnl  out  3  channel select to the A2D interface
- cnv_cmplt  in  1  level from the A2D interface; cleared by it the cycle after strt_cnv, set at end of conversion
- res  in  12  conversion result; valid while cnv_cmplt=1
- rd_ch  in  3  read channel select
- rd_data  out  12  averaged result for rd_ch; combinational; 0 if rd_ch>=NUM_CH
- scan_done  out  1  one-cycle pulse after the last channel of a pass is accumulated
- avg_vld  out  1  one-cycle pulse when new averages are published
- ovr  out  1  sticky overrun flag
- clr_ovr  in  1  clears ovr

## Operation
- Period counter `pcnt` (16b):
  - Counts only while en=1; held at 0 while en=0.
  - tick = en && pcnt==PERIOD-1, then pcnt wraps to 0.
- FSM states: IDLE, START, WAIT, ACC.
  - IDLE: on tick, set ch=0 and go to START.
  - START: strt_cnv=1 for exactly this cycle, then go to WAIT.
  - WAIT: leave on a cnv_cmplt rising edge (cnv_cmplt=1 and registered previous value=0), going to ACC. A flag still high from the previous conversion is never taken as complete.
  - ACC: acc[ch] += res.
    - If ch==NUM_CH-1, pulse scan_done and go to IDLE.
    - Otherwise ch++ and go to START.
- chnnl = ch. It is updated only on entry to START and held constant through START, WAIT and ACC. The A2D interface drives its command from chnnl continuously, so chnnl must not change during a conversion.
- Accumulators: NUM_CH regs of 12+AVG_LOG2 bits. No overflow is possible (max 2^AVG_LOG2 × 4095).
- Scan counter `scnt` (AVG_LOG2 bits) increments at each scan_done. On scan_done with scnt==2^AVG_LOG2-1:
  - result[i] = acc[i] >> AVG_LOG2 (truncate), for all i, in the same cycle.
  - For the channel being accumulated in that cycle, the new sample is included.
  - All acc cleared and avg_vld pulsed. scan_done and avg_vld are then coincident.
  - When AVG_LOG2=0, every scan publishes.
- Overrun: a tick while state!=IDLE sets ovr and is dropped; the current scan continues unaffected.
  - clr_ovr=1 clears ovr.
  - If set and clear occur in the same cycle, set wins.
- en falling mid-scan: the current scan completes normally; no further ticks occur.

## Timing
- Reset values:
  - strt_cnv=0, chnnl=0, scan_done=0, avg_vld=0, ovr=0.
  - All acc, result and scnt = 0, so rd_data=0.
  - pcnt=0, state=IDLE.
- Reset mid-scan returns to IDLE immediately. Partial accumulations are discarded.
- Tick in cycle T gives strt_cnv=1 in cycle T+1.
- A cnv_cmplt rising edge seen in cycle C gives ACC in C+1. The next channel's strt_cnv comes in C+2.
- Result update becomes visible on rd_data the cycle after ACC.
- Per-channel overhead beyond A2D latency is 3 cycles (START, edge detect, ACC). PERIOD must exceed NUM_CH×(A2D latency+3), otherwise ovr sets.
- The first tick occurs PERIOD cycles after en rises.

## Test plan
- Reset, then hold en=0 for 1000 cycles:
  - No strt_cnv.
  - rd_data=0 for all rd_ch.
  - ovr=0.
- Bench model with fixed 40-cycle A2D latency returning res=100×(ch+1); PERIOD=1000, NUM_CH=8, AVG_LOG2=0:
  - strt_cnv pulses 8 times per pass with chnnl 0..7, each pulse exactly 1 cycle wide.
  - chnnl is stable until the matching ACC.
  - scan_done and avg_vld are coincident.
  - rd_data reads 100..800.
- AVG_LOG2=2, channel 3 returns 10, 20, 30, 41 over four scans:
  - avg_vld only after the 4th scan.
  - rd_ch=3 reads 25 (101>>2).
  - Other channels are unchanged until then.
- PERIOD=200 with 40-cycle conversions (scan needs ~344 cycles):
  - ovr sets at the second tick and stays set.
  - Scans do not restart mid-pass.
  - clr_ovr pulsed in the same cycle as an overrun tick leaves ovr=1.
- Model holds cnv_cmplt=1 from the previous conversion for 1 extra cycle after strt_cnv:
  - The block does not advance until the true new rising edge.
  - The accumulated value matches the new res.
- rst_n asserted while in WAIT on channel 5, then released:
  - Outputs return to reset values asynchronously.
  - After release, the next tick restarts the scan at chnnl=0.
  - scnt=0 and rd_data=0 everywhere.

Source files
------------

// File: rtl/a2d_scan_sched.sv
// ============================================================================
// Module   : a2d_scan_sched
// Purpose  : Periodic A2D channel scanner with per-channel 2^AVG_LOG2 averaging
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module a2d_scan_sched #(
  parameter int NUM_CH   = 8,
  parameter int PERIOD   = 50000,
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        scan_done,
  output logic        avg_vld,
  output logic        ovr,
  input  logic        clr_ovr
);

  localparam int             ACW       = 12 + AVG_LOG2;
  localparam int             SCW       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [15:0]    PCNT_LAST = 16'(PERIOD - 1);
  localparam logic [SCW-1:0] SCNT_LAST = SCW'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]     CH_LAST   = 3'(NUM_CH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACC   = 2'd3;

  logic [1:0]     r_state;
  logic [1:0]     w_next;
  logic [15:0]    r_pcnt;
  logic           w_tick;
  logic [2:0]     r_ch;
  logic           r_cmplt_d;
  logic           w_cmplt_rise;
  logic [SCW-1:0] r_scnt;
  logic           w_publish;
  logic           r_ovr;
  logic [ACW-1:0] r_acc    [NUM_CH];
  logic [ACW-1:0] w_sum    [NUM_CH];
  logic [11:0]    r_result [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (!en || r_pcnt == PCNT_LAST) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  assign w_tick       = en && (r_pcnt == PCNT_LAST);
  // Only a fresh rising edge counts; a level left over from the last conversion is ignored
  assign w_cmplt_rise = cnv_cmplt && !r_cmplt_d;
  assign w_publish    = (r_scnt == SCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_tick) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (w_cmplt_rise) w_next = S_ACC;
      S_ACC:   w_next = (r_ch == CH_LAST) ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    strt_cnv  = (r_state == S_START);
    scan_done = (r_state == S_ACC) && (r_ch == CH_LAST);
    avg_vld   = scan_done && w_publish;
  end

  // Channel only moves on entry to START so chnnl is stable for the whole conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch      <= '0;
      r_cmplt_d <= 1'b0;
      r_scnt    <= '0;
      r_ovr     <= 1'b0;
    end else begin
      r_cmplt_d <= cnv_cmplt;
      if (r_state == S_IDLE && w_tick) begin
        r_ch <= '0;
      end else if (r_state == S_ACC && r_ch != CH_LAST) begin
        r_ch <= r_ch + 3'd1;
      end
      if (scan_done) begin
        r_scnt <= w_publish ? '0 : r_scnt + SCW'(1);
      end
      if (w_tick && r_state != S_IDLE) begin
        r_ovr <= 1'b1;
      end else if (clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign chnnl = r_ch;
  assign ovr   = r_ovr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sum
    assign w_sum[g] = r_acc[g] + ((r_ch == 3'(g)) ? ACW'(res) : '0);
  end

  // The publishing ACC folds its own sample in before the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i]    <= '0;
        r_result[i] <= '0;
      end
    end else if (r_state == S_ACC) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (avg_vld) begin
          r_result[i] <= w_sum[i][ACW-1:AVG_LOG2];
          r_acc[i]    <= '0;
        end else begin
          r_acc[i]    <= w_sum[i];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 3'(i)) rd_data = r_result[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_a2d_scan_sched.sv
// Directed bench for a2d_scan_sched: three instances (plain, averaging, overrun)
// driven by a fixed 40-cycle A2D model.
`default_nettype none

module tb_a2d_scan_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en     [3];
  logic        strt   [3];
  logic        cmplt  [3];
  logic        sd     [3];
  logic        av     [3];
  logic        ovr    [3];
  logic        clr    [3];
  logic        stale  [3];
  logic [2:0]  chnnl  [3];
  logic [2:0]  rd_ch  [3];
  logic [11:0] res    [3];
  logic [11:0] rd     [3];
  logic [11:0] tbl3   [4] = '{12'd10, 12'd20, 12'd30, 12'd41};

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  a2d_scan_sched #(.NUM_CH(8), .PERIOD(1000), .AVG_LOG2(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .strt_cnv(strt[0]), .chnnl(chnnl[0]),
    .cnv_cmplt(cmplt[0]), .res(res[0]), .rd_ch(rd_ch[0]), .rd_data(rd[0]),
    .scan_done(sd[0]), .avg_vld(av[0]), .ovr(ovr[0]), .clr_ovr(clr[0]));

  a2d_scan_sched #(.NUM_CH(8), .PERIOD(1000), .AVG_LOG2(2)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .strt_cnv(strt[1]), .chnnl(chnnl[1]),
    .cnv_cmplt(cmplt[1]), .res(res[1]), .rd_ch(rd_ch[1]), .rd_data(rd[1]),
    .scan_done(sd[1]), .avg_vld(av[1]), .ovr(ovr[1]), .clr_ovr(clr[1]));

  a2d_scan_sched #(.NUM_CH(8), .PERIOD(200), .AVG_LOG2(0)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .strt_cnv(strt[2]), .chnnl(chnnl[2]),
    .cnv_cmplt(cmplt[2]), .res(res[2]), .rd_ch(rd_ch[2]), .rd_data(rd[2]),
    .scan_done(sd[2]), .avg_vld(av[2]), .ovr(ovr[2]), .clr_ovr(clr[2]));

  // A2D model: 40 cycles from strt_cnv to cnv_cmplt; res changes only at completion
  int         m_cnt  [3];
  logic [2:0] m_ch   [3];
  logic       m_pend [3];
  int         m_n3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k]  <= 0;
        m_ch[k]   <= '0;
        m_pend[k] <= 1'b0;
        cmplt[k]  <= 1'b0;
        res[k]    <= '0;
      end
      m_n3 <= 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_pend[k] <= 1'b0;
        if (m_pend[k]) cmplt[k] <= 1'b0;
        if (strt[k]) begin
          m_cnt[k] <= 40;
          m_ch[k]  <= chnnl[k];
          if (stale[k]) m_pend[k] <= 1'b1;
          else          cmplt[k]  <= 1'b0;
        end else if (m_cnt[k] > 0) begin
          m_cnt[k] <= m_cnt[k] - 1;
          if (m_cnt[k] == 1) begin
            cmplt[k] <= 1'b1;
            if (k == 1 && m_ch[k] == 3'd3) begin
              res[k] <= (m_n3 < 4) ? tbl3[m_n3] : 12'd0;
              m_n3   <= m_n3 + 1;
            end else begin
              res[k] <= 12'(100 * (int'(m_ch[k]) + 1));
            end
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd_read(input int k, input logic [2:0] c, output logic [11:0] v);
    rd_ch[k] = c;
    #1;
    v = rd[k];
  endtask

  // One full pass of u0 starting from en rising; checks timing, pulses and results
  task automatic run_pass0(input string tag);
    int         n_s = 0, bad_w = 0, bad_ch = 0, bad_t = 0, bad_sd = 0, done_i = -1;
    logic       prev = 1'b0;
    logic [2:0] cur = '0;
    logic [11:0] v;
    @(negedge clk);
    en[0] = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (strt[0]) begin
        if (prev) bad_w++;
        if (int'(chnnl[0]) != n_s) bad_ch++;
        if (i != 1000 + 43 * n_s) bad_t++;
        cur = chnnl[0];
        n_s++;
      end else if (n_s > 0 && chnnl[0] !== cur) begin
        bad_ch++;
      end
      if (sd[0] !== av[0]) bad_sd++;
      prev = strt[0];
      if (sd[0]) begin
        done_i = i;
        break;
      end
    end
    en[0] = 1'b0;
    chk({tag, "_nstrt"}, n_s, 8);
    chk({tag, "_pulse_width"}, bad_w, 0);
    chk({tag, "_chnnl_seq_stable"}, bad_ch, 0);
    chk({tag, "_strt_timing"}, bad_t, 0);
    chk({tag, "_sd_av_coincide"}, bad_sd, 0);
    chk({tag, "_done_cycle"}, done_i, 1343);
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      rd_read(0, 3'(c), v);
      chk($sformatf("%s_rd%0d", tag, c), v, 100 * (c + 1));
    end
  endtask

  initial begin
    int          n_s, n_o, n_sd, n_av, bad_early, bad_t, bad_ch, bad_ovr, first_i, exp_t;
    logic        av4;
    logic [2:0]  first_ch;
    logic [11:0] v;

    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; clr[k] = 1'b0; rd_ch[k] = '0; stale[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_strt", strt[0], 0);
    chk("rst_chnnl", chnnl[0], 0);
    chk("rst_scan_done", sd[0], 0);
    chk("rst_avg_vld", av[0], 0);
    chk("rst_ovr", ovr[0], 0);
    rst_n = 1'b1;

    // Disabled: nothing happens for 1000 cycles
    n_s = 0; n_o = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (strt[0] || strt[1] || strt[2]) n_s++;
      if (ovr[0] || ovr[1] || ovr[2]) n_o++;
    end
    chk("idle_no_strt", n_s, 0);
    chk("idle_no_ovr", n_o, 0);
    for (int c = 0; c < 8; c++) begin
      rd_read(0, 3'(c), v);
      chk($sformatf("idle_rd%0d", c), v, 0);
    end

    // Plain scan, every pass publishes
    run_pass0("pass");

    // Averaging over four scans; channel 3 sees 10,20,30,41
    @(negedge clk);
    en[1] = 1'b1;
    n_sd = 0; n_av = 0; bad_early = 0; av4 = 1'b0;
    for (int i = 1; i <= 6000; i++) begin
      @(negedge clk);
      rd_ch[1] = 3'd3; #1; if (rd[1] !== 12'd0) bad_early++;
      rd_ch[1] = 3'd0; #1; if (rd[1] !== 12'd0) bad_early++;
      if (av[1]) n_av++;
      if (sd[1]) begin
        n_sd++;
        if (n_sd == 4) begin
          av4 = av[1];
          break;
        end
      end
    end
    en[1] = 1'b0;
    chk("avg_nscans", n_sd, 4);
    chk("avg_vld_count", n_av, 1);
    chk("avg_vld_on_4th", av4, 1);
    chk("avg_unchanged_early", bad_early, 0);
    @(negedge clk);
    rd_read(1, 3'd3, v); chk("avg_rd3", v, 25);
    rd_read(1, 3'd0, v); chk("avg_rd0", v, 100);
    rd_read(1, 3'd7, v); chk("avg_rd7", v, 800);

    // Overrun with PERIOD=200
    @(negedge clk);
    en[2] = 1'b1;
    n_s = 0; bad_t = 0; bad_ch = 0; bad_ovr = 0;
    for (int i = 1; i <= 990; i++) begin
      @(negedge clk);
      if (strt[2]) begin
        exp_t = (n_s < 8) ? 200 + 43 * n_s : 600 + 43 * (n_s - 8);
        if (i != exp_t) bad_t++;
        if (chnnl[2] !== 3'(n_s % 8)) bad_ch++;
        n_s++;
      end
      if (i == 399) chk("ovr_before", ovr[2], 0);
      if (i == 400) chk("ovr_second_tick", ovr[2], 1);
      if (i > 400 && i < 800 && ovr[2] !== 1'b1) bad_ovr++;
      if (i == 799) clr[2] = 1'b1;
      if (i == 800) begin
        chk("ovr_set_wins", ovr[2], 1);
        clr[2] = 1'b0;
      end
      if (i == 850) clr[2] = 1'b1;
      if (i == 851) begin
        chk("ovr_cleared", ovr[2], 0);
        clr[2] = 1'b0;
      end
    end
    en[2] = 1'b0;
    chk("ovr_nstrt", n_s, 16);
    chk("ovr_strt_timing", bad_t, 0);
    chk("ovr_no_restart", bad_ch, 0);
    chk("ovr_sticky", bad_ovr, 0);

    // Completion flag lingers one cycle after strt_cnv
    stale[0] = 1'b1;
    run_pass0("stale");
    stale[0] = 1'b0;

    // Asynchronous reset while waiting on channel 5
    @(negedge clk);
    en[0] = 1'b1;
    repeat (1230) @(negedge clk);
    chk("mid_chnnl5", chnnl[0], 5);
    chk("mid_in_wait", strt[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_chnnl", chnnl[0], 0);
    chk("arst_strt", strt[0], 0);
    chk("arst_sd", sd[0], 0);
    chk("arst_ovr", ovr[0], 0);
    rd_read(0, 3'd0, v); chk("arst_rd0", v, 0);
    rd_read(0, 3'd7, v); chk("arst_rd7", v, 0);
    rd_read(1, 3'd0, v); chk("arst_u1_rd0", v, 0);
    @(negedge clk);
    rst_n = 1'b1;
    first_i = -1; first_ch = 3'd7;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      if (strt[0]) begin
        first_i  = i;
        first_ch = chnnl[0];
        break;
      end
    end
    en[0] = 1'b0;
    chk("post_rst_first_strt", first_i, 1000);
    chk("post_rst_chnnl", first_ch, 0);

    if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
